matmul_stream_io: RTL and testbench

- Sequential streaming front-end for the combinational core `matrix_multiplication_accumulation`, which computes D = A·B + C. The core is instantiated inside this block.
- Accepts the A, B and C operand elements one word at a time over a valid/ready input stream. Holds them in operand registers until all are loaded.
- Then streams the D result elements out one word at a time over a valid/ready output stream.
- Used to drive the array from a narrow bus (DMA or host link) instead of wide parallel ports.

---
 rtl/matmul_stream_io.sv | 250 +++++++++++++++++++++++++
 tb/tb_matmul_stream_io.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_io.sv
// Streaming valid/ready front-end around the combinational D = A*B + C core.
// Define MATMUL_STREAM_HEADER_EN to require a matching M/N/K header word before each job.

module matrix_multiplication_accumulation #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2,
  parameter int unsigned K = 2,
  parameter int unsigned P = 8
) (
  input  logic [M*K*P-1:0]   a,
  input  logic [K*N*P-1:0]   b,
  input  logic [M*N*4*P-1:0] c,
  output logic [M*N*4*P-1:0] d
);
  localparam int unsigned W = 4 * P;

  logic [W-1:0] acc;
  logic [W-1:0] a_ext;
  logic [W-1:0] b_ext;

  // Operands are sign-extended to W bits; the W-bit product/sum then wraps modulo 2^W.
  always_comb begin
    d     = '0;
    acc   = '0;
    a_ext = '0;
    b_ext = '0;
    for (int unsigned i = 0; i < M; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        acc = c[(i*N+j)*W +: W];
        for (int unsigned kk = 0; kk < K; kk++) begin
          a_ext = {{(W-P){a[(i*K+kk)*P+P-1]}}, a[(i*K+kk)*P +: P]};
          b_ext = {{(W-P){b[(kk*N+j)*P+P-1]}}, b[(kk*N+j)*P +: P]};
          acc   = acc + a_ext * b_ext;
        end
        d[(i*N+j)*W +: W] = acc;
      end
    end
  end
endmodule

module matmul_stream_io #(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2,
  parameter int unsigned K = 2,
  parameter int unsigned P = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [4*P-1:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*P-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           done,
  output logic           hdr_err
);
  localparam int unsigned W      = 4 * P;
  localparam int unsigned NumA   = M * K;
  localparam int unsigned NumB   = K * N;
  localparam int unsigned NumC   = M * N;
  localparam int unsigned NumAB  = (NumA > NumB) ? NumA : NumB;
  localparam int unsigned NumMax = (NumAB > NumC) ? NumAB : NumC;
  localparam int unsigned IdxW   = $clog2(NumMax + 1);

  localparam logic [IdxW-1:0] LastA = IdxW'(NumA - 1);
  localparam logic [IdxW-1:0] LastB = IdxW'(NumB - 1);
  localparam logic [IdxW-1:0] LastC = IdxW'(NumC - 1);

  localparam logic [2:0] StLoadA   = 3'd0;
  localparam logic [2:0] StLoadB   = 3'd1;
  localparam logic [2:0] StLoadC   = 3'd2;
  localparam logic [2:0] StCompute = 3'd3;
  localparam logic [2:0] StEmit    = 3'd4;
`ifdef MATMUL_STREAM_HEADER_EN
  localparam logic [2:0] StHdr     = 3'd5;
  localparam logic [2:0] StIdle    = StHdr;
`else
  localparam logic [2:0] StIdle    = StLoadA;
`endif

  logic [2:0]        state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NumA*P-1:0] a_q, a_d;
  logic [NumB*P-1:0] b_q, b_d;
  logic [NumC*W-1:0] c_q, c_d;
  logic [NumC*W-1:0] d_q, d_d;
  logic [NumC*W-1:0] core_d;
  logic              done_q, done_d;
  logic              load_st;
  logic              in_fire;
  logic              out_fire;

  matrix_multiplication_accumulation #(
    .M (M),
    .N (N),
    .K (K),
    .P (P)
  ) u_core (
    .a (a_q),
    .b (b_q),
    .c (c_q),
    .d (core_d)
  );

  always_comb begin
    load_st = (state_q == StLoadA) || (state_q == StLoadB) || (state_q == StLoadC);
`ifdef MATMUL_STREAM_HEADER_EN
    load_st = load_st || (state_q == StHdr);
`endif
  end

  // Gated by rst_n so the input side refuses words while reset is held.
  assign in_ready  = rst_n && load_st;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state_q == StEmit);
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? d_q[idx_q*W +: W] : '0;
  assign done      = done_q;

  always_comb begin
    busy = !((state_q == StLoadA) && (idx_q == '0));
`ifdef MATMUL_STREAM_HEADER_EN
    if (state_q == StHdr) begin
      busy = 1'b0;
    end
`endif
  end

`ifdef MATMUL_STREAM_HEADER_EN
  logic hdr_err_q, hdr_err_d;
  logic hdr_match;

  assign hdr_match = (in_data[23:16] == 8'(M)) && (in_data[15:8] == 8'(N)) &&
                     (in_data[7:0] == 8'(K));
  assign hdr_err   = hdr_err_q;
`else
  assign hdr_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    done_d  = 1'b0;
`ifdef MATMUL_STREAM_HEADER_EN
    hdr_err_d = hdr_err_q;
`endif
    unique case (state_q)
      StLoadA: begin
        if (in_fire) begin
          a_d[idx_q*P +: P] = in_data[P-1:0];
          if (idx_q == LastA) begin
            idx_d   = '0;
            state_d = StLoadB;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StLoadB: begin
        if (in_fire) begin
          b_d[idx_q*P +: P] = in_data[P-1:0];
          if (idx_q == LastB) begin
            idx_d   = '0;
            state_d = StLoadC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StLoadC: begin
        if (in_fire) begin
          c_d[idx_q*W +: W] = in_data;
          if (idx_q == LastC) begin
            idx_d   = '0;
            state_d = StCompute;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StCompute: begin
        d_d     = core_d;
        state_d = StEmit;
      end
      StEmit: begin
        if (out_fire) begin
          if (idx_q == LastC) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef MATMUL_STREAM_HEADER_EN
      StHdr: begin
        if (in_fire) begin
          if (hdr_match) begin
            state_d = StLoadA;
          end else begin
            hdr_err_d = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      done_q  <= done_d;
    end
  end

`ifdef MATMUL_STREAM_HEADER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_err_q <= 1'b0;
    end else begin
      hdr_err_q <= hdr_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_matmul_stream_io.sv
// Randomized self-checking bench for matmul_stream_io against an arithmetic D = A*B + C model.
// Header-mode checks are compiled in when MATMUL_STREAM_HEADER_EN is defined.

module tb_matmul_stream_io;
  localparam int M  = 2;
  localparam int N  = 2;
  localparam int K  = 2;
  localparam int NA = M * K;
  localparam int NB = K * N;
  localparam int NC = M * N;
`ifdef MATMUL_STREAM_HEADER_EN
  localparam int NumWords = NA + NB + NC + 1;
`else
  localparam int NumWords = NA + NB + NC;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        hdr_err;

  matmul_stream_io #(
    .M (M),
    .N (N),
    .K (K),
    .P (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .hdr_err   (hdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          in_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] job_q[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d) at %0t",
                  tag, obs, $signed(obs), exp, $signed(exp), $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer matrix arithmetic, 32-bit wrap from int overflow.
  task automatic build_exp();
    int a[M][K];
    int b[K][N];
    int c[M][N];
    int s;
    exp_q.delete();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) a[i][k] = int'($signed(job_q[i*K+k][7:0]));
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) b[k][j] = int'($signed(job_q[NA+k*N+j][7:0]));
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) c[i][j] = int'(job_q[NA+NB+i*N+j]);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = c[i][j];
        for (int k = 0; k < K; k++) s = s + a[i][k] * b[k][j];
        exp_q.push_back(32'(s));
      end
  endtask

  function automatic logic pol(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k < 3) ? 1'b0 : ((k - 3) % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) in_cnt++;
      if (done) done_cnt++;
      if (out_valid) check("in_ready_in_emit", {31'b0, in_ready}, 32'd0);
      if (prev_stall) begin
        check("stall_data_hold", out_data, prev_data);
        check("stall_valid_hold", {31'b0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit hs;
    hs       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      step();
    end
    if (!hs) check("in_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_hdr();
`ifdef MATMUL_STREAM_HEADER_EN
    send_word(32'h0002_0202);
`endif
  endtask

  task automatic set_case1();
    job_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
              32'd10, 32'd20, 32'd30, 32'd40};
  endtask

  task automatic run_job(input int mode, input bit gaps, input bit hold);
    int k;
    int g;
    build_exp();
    got_q.delete();
    done_cnt  = 0;
    in_cnt    = 0;
    out_ready = 1'b0;
    send_hdr();
    for (int i = 0; i < job_q.size(); i++) begin
      if (gaps) begin
        g        = $urandom_range(0, 2);
        in_valid = 1'b0;
        in_data  = $urandom();
        repeat (g) step();
      end
      send_word(job_q[i]);
    end
    in_valid  = hold;
    in_data   = $urandom();
    out_ready = pol(mode, 0);
    @(negedge clk);
    check("latency_compute_valid", {31'b0, out_valid}, 32'd0);
    check("busy_in_compute", {31'b0, busy}, 32'd1);
    step();
    @(negedge clk);
    check("latency_emit_valid", {31'b0, out_valid}, 32'd1);
    k = 0;
    while (got_q.size() < NC && k < 300) begin
      step();
      k++;
      out_ready = pol(mode, k);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rx_count", got_q.size(), NC);
    for (int i = 0; i < NC; i++)
      if (i < got_q.size()) check("d_value", got_q[i], exp_q[i]);
    check("done_pulses", done_cnt, 32'd1);
    check("words_consumed", in_cnt, NumWords);
    check("busy_after_job", {31'b0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_hdr_err"}, {31'b0, hdr_err}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lit[4] = '{29, 42, 73, 90};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Basic job
    set_case1();
    run_job(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check("case1_literal", got_q[i], 32'(lit[i]));

    // Signed operands with ignored upper bits
    job_q = '{32'h0000_ABFF, 32'h0000_ABFF, 32'h0000_ABFF, 32'h0000_ABFF,
              32'h0000_0080, 32'h0000_0080, 32'h0000_0080, 32'h0000_0080,
              32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    run_job(0, 1'b0, 1'b0);
    if (got_q.size() > 0) check("signed_literal", got_q[0], 32'd251);

    // Backpressure, then gaps with in_valid held through emit
    set_case1();
    run_job(1, 1'b0, 1'b0);
    set_case1();
    run_job(0, 1'b1, 1'b1);

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      job_q.delete();
      for (int i = 0; i < NA + NB + NC; i++) job_q.push_back($urandom());
      run_job($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of loading
    set_case1();
    send_hdr();
    for (int i = 0; i < 5; i++) send_word(job_q[i]);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_load");
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run_job(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check("after_rst_load", got_q[i], 32'(lit[i]));

    // Reset in the middle of emitting
    send_hdr();
    for (int i = 0; i < NA + NB + NC; i++) send_word(job_q[i]);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    @(negedge clk);
    check("emit_before_reset", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_emit");
    step();
    step();
    rst_n = 1'b1;
    step();
    run_job(2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check("after_rst_emit", got_q[i], 32'(lit[i]));

`ifdef MATMUL_STREAM_HEADER_EN
    send_word(32'h0002_0203);
    in_valid = 1'b0;
    @(negedge clk);
    check("hdr_err_set", {31'b0, hdr_err}, 32'd1);
    step();
    run_job(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) check("hdr_case1", got_q[i], 32'(lit[i]));
    check("hdr_err_sticky", {31'b0, hdr_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("hdr_err_cleared", {31'b0, hdr_err}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
`else
    check("hdr_err_tied_low", {31'b0, hdr_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
